// File: rtl/cx_order_router.sv
// cx_order_router: routes one CXU master to NUM_SLAVES slaves and returns responses in issue order.
// Optional macro CX_ROUTER_ERR_RESP_EN: out-of-range requests get a locally generated error response.
module cx_order_router #(
  parameter int NUM_SLAVES         = 2,
  parameter int MAX_OUTSTANDING    = 4,
  parameter int C_M_CXU_REQ_ID_W   = 3,
  parameter int C_M_CXU_CXU_ID_W   = 4,
  parameter int C_M_CXU_STATE_ID_W = 3,
  parameter int C_M_CXU_FUNC_ID_W  = 10,
  parameter int C_M_CXU_INSN_W     = 32,
  parameter int C_M_CXU_DATA_W     = 32,
  parameter int C_M_CXU_STATUS_W   = 3
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     s_req_valid,
  output logic                                     s_req_ready,
  input  logic [C_M_CXU_REQ_ID_W-1:0]              s_req_id,
  input  logic [C_M_CXU_CXU_ID_W-1:0]              s_req_cxu,
  input  logic [C_M_CXU_STATE_ID_W-1:0]            s_req_state,
  input  logic [C_M_CXU_FUNC_ID_W-1:0]             s_req_func,
  input  logic [C_M_CXU_INSN_W-1:0]                s_req_insn,
  input  logic [C_M_CXU_DATA_W-1:0]                s_req_data0,
  input  logic [C_M_CXU_DATA_W-1:0]                s_req_data1,
  output logic                                     s_resp_valid,
  input  logic                                     s_resp_ready,
  output logic [C_M_CXU_REQ_ID_W-1:0]              s_resp_id,
  output logic [C_M_CXU_STATUS_W-1:0]              s_resp_status,
  output logic [C_M_CXU_DATA_W-1:0]                s_resp_data,
  output logic [NUM_SLAVES-1:0]                    m_req_valid,
  input  logic [NUM_SLAVES-1:0]                    m_req_ready,
  output logic [C_M_CXU_REQ_ID_W-1:0]              m_req_id,
  output logic [C_M_CXU_STATE_ID_W-1:0]            m_req_state,
  output logic [C_M_CXU_FUNC_ID_W-1:0]             m_req_func,
  output logic [C_M_CXU_INSN_W-1:0]                m_req_insn,
  output logic [C_M_CXU_DATA_W-1:0]                m_req_data0,
  output logic [C_M_CXU_DATA_W-1:0]                m_req_data1,
  input  logic [NUM_SLAVES-1:0]                    m_resp_valid,
  output logic [NUM_SLAVES-1:0]                    m_resp_ready,
  input  logic [NUM_SLAVES*C_M_CXU_REQ_ID_W-1:0]   m_resp_id,
  input  logic [NUM_SLAVES*C_M_CXU_STATUS_W-1:0]   m_resp_status,
  input  logic [NUM_SLAVES*C_M_CXU_DATA_W-1:0]     m_resp_data
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int ID_W  = C_M_CXU_REQ_ID_W;

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [SEL_W-1:0] selFifo_q [MAX_OUTSTANDING];
`ifdef CX_ROUTER_ERR_RESP_EN
  logic             errFifo_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]  idFifo_q  [MAX_OUTSTANDING];
`endif

  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] headSel;
  logic             inRange;
  logic             full;
  logic             notEmpty;
  logic             selReady;
  logic             accept;
  logic             push;
  logic             pop;

  assign sel      = s_req_cxu[SEL_W-1:0];
  assign inRange  = 32'(s_req_cxu) < NUM_SLAVES;
  assign full     = count_q == (PTR_W+1)'(MAX_OUTSTANDING);
  assign notEmpty = count_q != '0;
  assign headSel  = selFifo_q[rdPtr_q];

  assign m_req_id    = s_req_id;
  assign m_req_state = s_req_state;
  assign m_req_func  = s_req_func;
  assign m_req_insn  = s_req_insn;
  assign m_req_data0 = s_req_data0;
  assign m_req_data1 = s_req_data1;

  // Full blocks acceptance outright, even when a pop happens in the same cycle.
  always_comb begin
    selReady    = 1'b0;
    m_req_valid = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel == SEL_W'(k)) begin
        selReady       = m_req_ready[k];
        m_req_valid[k] = !i_rst && s_req_valid && inRange && !full;
      end
    end
    if (i_rst) begin
      s_req_ready = 1'b0;
    end else if (inRange) begin
      s_req_ready = !full && selReady;
    end else begin
      s_req_ready = !full;
    end
  end

  assign accept = s_req_valid && s_req_ready;
`ifdef CX_ROUTER_ERR_RESP_EN
  assign push = accept;
`else
  assign push = accept && inRange;
`endif

  // Only the slave at the FIFO head may hand over a response; others stall.
  always_comb begin
    s_resp_valid  = 1'b0;
    s_resp_id     = '0;
    s_resp_status = '0;
    s_resp_data   = '0;
    m_resp_ready  = '0;
    if (!i_rst && notEmpty) begin
`ifdef CX_ROUTER_ERR_RESP_EN
      if (errFifo_q[rdPtr_q]) begin
        s_resp_valid  = 1'b1;
        s_resp_id     = idFifo_q[rdPtr_q];
        s_resp_status = '1;
      end else
`endif
      begin
        for (int k = 0; k < NUM_SLAVES; k++) begin
          if (headSel == SEL_W'(k)) begin
            s_resp_valid    = m_resp_valid[k];
            s_resp_id       = m_resp_id[k*ID_W +: ID_W];
            s_resp_status   = m_resp_status[k*C_M_CXU_STATUS_W +: C_M_CXU_STATUS_W];
            s_resp_data     = m_resp_data[k*C_M_CXU_DATA_W +: C_M_CXU_DATA_W];
            m_resp_ready[k] = s_resp_ready;
          end
        end
      end
    end
  end

  assign pop = s_resp_valid && s_resp_ready;

  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(push);
    rdPtr_d = rdPtr_q + PTR_W'(pop);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: count_q gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      selFifo_q[wrPtr_q] <= inRange ? sel : '0;
`ifdef CX_ROUTER_ERR_RESP_EN
      errFifo_q[wrPtr_q] <= !inRange;
      idFifo_q[wrPtr_q]  <= s_req_id;
`endif
    end
  end

endmodule

// File: tb/tb_cx_order_router.sv
// tb_cx_order_router: directed checks of routing, in-order responses, full handling and pointer wrap.
module tb_cx_order_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        sReqValid, sReqReady;
  logic [2:0]  sReqId;
  logic [3:0]  sReqCxu;
  logic [2:0]  sReqState;
  logic [9:0]  sReqFunc;
  logic [31:0] sReqInsn, sReqData0, sReqData1;
  logic        sRespValid, sRespReady;
  logic [2:0]  sRespId, sRespStatus;
  logic [31:0] sRespData;
  logic [3:0]  mReqValid, mReqReady;
  logic [2:0]  mReqId, mReqState;
  logic [9:0]  mReqFunc;
  logic [31:0] mReqInsn, mReqData0, mReqData1;
  logic [3:0]  mRespValid, mRespReady;
  logic [11:0] mRespId, mRespStatus;
  logic [127:0] mRespData;
  logic [2:0]  slvId [4];
  logic [31:0] slvData [4];

  int errors = 0;
  int checks = 0;
  int expSel[$];

  always #5 clk = ~clk;

  always_comb begin
    mRespId     = '0;
    mRespStatus = '0;
    mRespData   = '0;
    for (int k = 0; k < 4; k++) begin
      mRespId[k*3 +: 3]     = slvId[k];
      mRespStatus[k*3 +: 3] = 3'(k);
      mRespData[k*32 +: 32] = slvData[k];
    end
  end

  cx_order_router #(.NUM_SLAVES(4), .MAX_OUTSTANDING(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .s_req_valid(sReqValid), .s_req_ready(sReqReady), .s_req_id(sReqId), .s_req_cxu(sReqCxu),
    .s_req_state(sReqState), .s_req_func(sReqFunc), .s_req_insn(sReqInsn),
    .s_req_data0(sReqData0), .s_req_data1(sReqData1),
    .s_resp_valid(sRespValid), .s_resp_ready(sRespReady), .s_resp_id(sRespId),
    .s_resp_status(sRespStatus), .s_resp_data(sRespData),
    .m_req_valid(mReqValid), .m_req_ready(mReqReady), .m_req_id(mReqId),
    .m_req_state(mReqState), .m_req_func(mReqFunc), .m_req_insn(mReqInsn),
    .m_req_data0(mReqData0), .m_req_data1(mReqData1),
    .m_resp_valid(mRespValid), .m_resp_ready(mRespReady), .m_resp_id(mRespId),
    .m_resp_status(mRespStatus), .m_resp_data(mRespData)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] cxu, input logic [2:0] id);
    sReqValid = valid;
    sReqCxu   = cxu;
    sReqId    = id;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 4'd0, 3'd0);
    sReqState = 3'd1; sReqFunc = 10'd9; sReqInsn = 32'h1234_5678;
    sReqData0 = 32'hCAFE_0000; sReqData1 = 32'h0000_BEEF;
    mReqReady = 4'hF; sRespReady = 1'b1; mRespValid = 4'h0;
    for (int k = 0; k < 4; k++) begin slvId[k] = 3'd0; slvData[k] = 32'd0; end
    tick; tick;
    checkOutput("rst_req_ready", {31'd0, sReqReady}, 32'd0);
    checkOutput("rst_m_req_valid", {28'd0, mReqValid}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, sRespValid}, 32'd0);
    checkOutput("rst_m_resp_ready", {28'd0, mRespReady}, 32'd0);

    // Idle after reset
    rst = 1'b0;
    applyStimulus(1'b0, 4'd1, 3'd0);
    #1;
    checkOutput("idle_req_ready", {31'd0, sReqReady}, 32'd1);
    checkOutput("idle_m_req_valid", {28'd0, mReqValid}, 32'd0);
    checkOutput("idle_resp_valid", {31'd0, sRespValid}, 32'd0);

    // Single request to slave 2
    applyStimulus(1'b1, 4'd2, 3'd5);
    mReqReady = 4'b0100;
    #1;
    checkOutput("route_m_req_valid", {28'd0, mReqValid}, 32'h4);
    checkOutput("route_req_ready", {31'd0, sReqReady}, 32'd1);
    checkOutput("route_m_req_id", {29'd0, mReqId}, 32'd5);
    checkOutput("route_m_req_data0", mReqData0, 32'hCAFE_0000);
    mReqReady = 4'b1011;
    #1;
    checkOutput("bp_req_ready", {31'd0, sReqReady}, 32'd0);
    checkOutput("bp_m_req_valid", {28'd0, mReqValid}, 32'h4);
    mReqReady = 4'b0100;
    #1;
    tick;
    sReqValid = 1'b0;
    slvId[2] = 3'd5; slvData[2] = 32'hDEAD; mRespValid = 4'b0100;
    #1;
    checkOutput("resp_valid", {31'd0, sRespValid}, 32'd1);
    checkOutput("resp_id", {29'd0, sRespId}, 32'd5);
    checkOutput("resp_data", sRespData, 32'hDEAD);
    checkOutput("resp_m_ready", {28'd0, mRespReady}, 32'h4);
    tick;
    checkOutput("empty_resp_valid", {31'd0, sRespValid}, 32'd0);
    checkOutput("empty_m_resp_ready", {28'd0, mRespReady}, 32'd0);
    mRespValid = 4'h0;

    // Out-of-order completion is held until the head returns
    mReqReady = 4'hF;
    applyStimulus(1'b1, 4'd0, 3'd1);
    #1; tick;
    applyStimulus(1'b1, 4'd1, 3'd2);
    #1; tick;
    sReqValid = 1'b0;
    slvId[1] = 3'd2; slvData[1] = 32'h22; mRespValid = 4'b0010;
    #1;
    checkOutput("ord_hold_valid", {31'd0, sRespValid}, 32'd0);
    checkOutput("ord_hold_ready", {28'd0, mRespReady}, 32'h1);
    tick;
    checkOutput("ord_hold2_valid", {31'd0, sRespValid}, 32'd0);
    slvId[0] = 3'd1; slvData[0] = 32'h11; mRespValid = 4'b0011;
    #1;
    checkOutput("ord_first_valid", {31'd0, sRespValid}, 32'd1);
    checkOutput("ord_first_id", {29'd0, sRespId}, 32'd1);
    checkOutput("ord_first_data", sRespData, 32'h11);
    tick;
    mRespValid = 4'b0010;
    #1;
    checkOutput("ord_second_valid", {31'd0, sRespValid}, 32'd1);
    checkOutput("ord_second_id", {29'd0, sRespId}, 32'd2);
    checkOutput("ord_second_ready", {28'd0, mRespReady}, 32'h2);
    tick;
    mRespValid = 4'h0;
    #1;
    checkOutput("ord_done_valid", {31'd0, sRespValid}, 32'd0);

    // Fill to MAX_OUTSTANDING, then a fifth request with a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'd3, 3'(i));
      #1;
      checkOutput("fill_req_ready", {31'd0, sReqReady}, 32'd1);
      tick;
    end
    applyStimulus(1'b1, 4'd3, 3'd4);
    #1;
    checkOutput("full_req_ready", {31'd0, sReqReady}, 32'd0);
    checkOutput("full_m_req_valid", {28'd0, mReqValid}, 32'd0);
    slvId[3] = 3'd0; slvData[3] = 32'h30; mRespValid = 4'b1000;
    #1;
    checkOutput("full_pop_valid", {31'd0, sRespValid}, 32'd1);
    checkOutput("full_pop_req_ready", {31'd0, sReqReady}, 32'd0);
    tick;
    mRespValid = 4'h0;
    #1;
    checkOutput("after_pop_req_ready", {31'd0, sReqReady}, 32'd1);
    checkOutput("after_pop_m_req_valid", {28'd0, mReqValid}, 32'h8);
    tick;
    sReqValid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      slvId[3] = 3'(i); slvData[3] = 32'h30 + 32'(i); mRespValid = 4'b1000;
      #1;
      checkOutput("drain_valid", {31'd0, sRespValid}, 32'd1);
      checkOutput("drain_data", sRespData, 32'h30 + 32'(i));
      tick;
    end
    #1;
    checkOutput("drained_valid", {31'd0, sRespValid}, 32'd0);
    mRespValid = 4'h0;

    // Back-to-back burst of 10: pointers wrap twice
    for (int k = 0; k < 4; k++) slvData[k] = 32'hA0 + 32'(k);
    mRespValid = 4'hF;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) applyStimulus(1'b1, 4'(i % 4), 3'(i % 8));
      else sReqValid = 1'b0;
      #1;
      checkOutput("burst_resp_valid", {31'd0, sRespValid}, {31'd0, expSel.size() > 0});
      if (expSel.size() > 0)
        checkOutput("burst_resp_data", sRespData, 32'hA0 + 32'(expSel[0]));
      if (i < 10) checkOutput("burst_req_ready", {31'd0, sReqReady}, 32'd1);
      tick;
      if (expSel.size() > 0) void'(expSel.pop_front());
      if (i < 10) expSel.push_back(i % 4);
    end

    // Reset in the middle of outstanding traffic
    mRespValid = 4'h0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'(i), 3'(i));
      #1; tick;
    end
    sReqValid = 1'b0;
    sReqCxu = 4'd0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mRespValid = 4'hF;
    #1;
    checkOutput("midrst_resp_valid", {31'd0, sRespValid}, 32'd0);
    checkOutput("midrst_m_resp_ready", {28'd0, mRespReady}, 32'd0);
    checkOutput("midrst_req_ready", {31'd0, sReqReady}, 32'd1);
    mRespValid = 4'h0;

    // Out-of-range target
    applyStimulus(1'b1, 4'd7, 3'd3);
    #1;
    checkOutput("oor_req_ready", {31'd0, sReqReady}, 32'd1);
    checkOutput("oor_m_req_valid", {28'd0, mReqValid}, 32'd0);
    tick;
    sReqValid = 1'b0;
    slvData[0] = 32'h55; mRespValid = 4'b0001;
    #1;
`ifdef CX_ROUTER_ERR_RESP_EN
    checkOutput("err_resp_valid", {31'd0, sRespValid}, 32'd1);
    checkOutput("err_resp_id", {29'd0, sRespId}, 32'd3);
    checkOutput("err_resp_status", {29'd0, sRespStatus}, 32'd7);
    checkOutput("err_resp_data", sRespData, 32'd0);
    checkOutput("err_m_resp_ready", {28'd0, mRespReady}, 32'd0);
    tick;
    checkOutput("err_popped_valid", {31'd0, sRespValid}, 32'd0);
`else
    checkOutput("oor_no_resp_valid", {31'd0, sRespValid}, 32'd0);
    checkOutput("oor_m_resp_ready", {28'd0, mRespReady}, 32'd0);
`endif
    mRespValid = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
